ka_partial_products_50bit: RTL and testbench



---
 rtl/ka_partial_products_50bit.sv | 126 ++++++++++++
 tb/tb_ka_partial_products_50bit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/ka_partial_products_50bit.sv
// One-level Karatsuba front end for GF(2) multiplication: three
// half-width carry-less products from one shared bit-serial multiplier.
module ka_partial_products_50bit #(
    parameter int N = 50
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-2:0] p_lo,
    output logic [N-2:0] p_mid,
    output logic [N-2:0] p_hi
);
    localparam int H  = N / 2;
    localparam int CW = $clog2(H);

    typedef enum logic [2:0] {
        IDLE,
        MUL_LO,
        MUL_HI,
        MUL_MID,
        DONE
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [N-1:0]  r_a;
    logic [N-1:0]  r_b;
    logic [N-2:0]  r_acc;
    logic [CW-1:0] r_cnt;
    logic [N-2:0]  r_p_lo;
    logic [N-2:0]  r_p_mid;
    logic [N-2:0]  r_p_hi;
    logic [H-1:0]  w_x;
    logic [H-1:0]  w_m;
    logic          w_mbit;
    logic [N-2:0]  w_acc_nxt;
    logic          w_accept;
    logic          w_last;

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign p_lo      = r_p_lo;
    assign p_mid     = r_p_mid;
    assign p_hi      = r_p_hi;
    assign w_accept  = in_valid && in_ready;
    assign w_last    = (r_cnt == '0);

    // Operand selection for the shared multiplier, per pass
    always_comb begin
        w_x = '0;
        w_m = '0;
        unique case (r_state)
            MUL_LO: begin
                w_x = r_a[H-1:0];
                w_m = r_b[H-1:0];
            end
            MUL_HI: begin
                w_x = r_a[N-1:H];
                w_m = r_b[N-1:H];
            end
            MUL_MID: begin
                w_x = r_a[H-1:0] ^ r_a[N-1:H];
                w_m = r_b[H-1:0] ^ r_b[N-1:H];
            end
            default: ;
        endcase
    end

    assign w_mbit    = w_m[r_cnt];
    assign w_acc_nxt = {r_acc[N-3:0], 1'b0}
                     ^ (w_mbit ? {{(N-1-H){1'b0}}, w_x} : '0);

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (w_accept) w_state_nxt = MUL_LO;
            MUL_LO:  if (w_last) w_state_nxt = MUL_HI;
            MUL_HI:  if (w_last) w_state_nxt = MUL_MID;
            MUL_MID: if (w_last) w_state_nxt = DONE;
            DONE:    if (out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_cnt   <= CW'(H - 1);
            r_p_lo  <= '0;
            r_p_mid <= '0;
            r_p_hi  <= '0;
        end else if (r_state == IDLE) begin
            if (w_accept) begin
                r_a   <= a;
                r_b   <= b;
                r_acc <= '0;
                r_cnt <= CW'(H - 1);
            end
        end else if (r_state != DONE) begin
            if (w_last) begin
                r_acc <= '0;
                r_cnt <= CW'(H - 1);
                if (r_state == MUL_LO) r_p_lo <= w_acc_nxt;
                if (r_state == MUL_HI) r_p_hi <= w_acc_nxt;
                // Fold the outer products into the middle term here
                if (r_state == MUL_MID)
                    r_p_mid <= w_acc_nxt ^ r_p_lo ^ r_p_hi;
            end else begin
                r_acc <= w_acc_nxt;
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ka_partial_products_50bit.sv
// Bench for ka_partial_products_50bit: directed table, random ops against
// a carry-less product model, back-pressure and mid-operation reset.
module tb_ka_partial_products_50bit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [49:0] a = '0;
    logic [49:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [48:0] p_lo, p_mid, p_hi;

    int n_chk = 0;
    int n_fail = 0;

    ka_partial_products_50bit #(.N(50)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .p_lo(p_lo), .p_mid(p_mid), .p_hi(p_hi)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [49:0] a;
        logic [49:0] b;
        logic [48:0] lo;
        logic [48:0] mid;
        logic [48:0] hi;
    } vec_t;

    function automatic logic [98:0] clmul(input logic [49:0] x,
                                          input logic [49:0] y);
        logic [98:0] r;
        r = '0;
        for (int i = 0; i < 50; i++)
            if (y[i]) r = r ^ ({49'b0, x} << i);
        return r;
    endfunction

    function automatic vec_t model(input logic [49:0] x,
                                   input logic [49:0] y);
        vec_t v;
        logic [98:0] lo, hi, mm;
        lo = clmul({25'b0, x[24:0]}, {25'b0, y[24:0]});
        hi = clmul({25'b0, x[49:25]}, {25'b0, y[49:25]});
        mm = clmul({25'b0, x[24:0] ^ x[49:25]},
                   {25'b0, y[24:0] ^ y[49:25]});
        v.a = x;
        v.b = y;
        v.lo = lo[48:0];
        v.hi = hi[48:0];
        v.mid = mm[48:0] ^ lo[48:0] ^ hi[48:0];
        return v;
    endfunction

    task automatic chk(input string name, input logic [98:0] act,
                       input logic [98:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [49:0] rnd50();
        return {$urandom_range(32'h3ffff), $urandom()};
    endfunction

    // Runs one operation; holds out_ready low for `hold` cycles of DONE.
    task automatic run_op(input vec_t v, input int hold, input bit junk,
                          input string tag);
        int lat;
        bit bad;
        logic [48:0] lo, mid, hi;
        logic [98:0] ovl;
        @(negedge clk);
        chk({tag, "_in_ready_idle"}, 99'(in_ready), 99'(1));
        a = v.a;
        b = v.b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = rnd50();
        b = rnd50();
        lat = 0;
        bad = 0;
        while (!out_valid && lat < 200) begin
            if (junk) in_valid = 1'($urandom_range(1));
            @(posedge clk);
            lat++;
            #1;
            if (!out_valid && in_ready) bad = 1;
        end
        in_valid = 1'b0;
        if (!out_valid) begin
            chk({tag, "_timeout"}, 99'(0), 99'(1));
            return;
        end
        chk({tag, "_latency"}, 99'(lat + 1), 99'(76));
        chk({tag, "_busy_in_ready"}, 99'(bad), 99'(0));
        lo = p_lo;
        mid = p_mid;
        hi = p_hi;
        chk({tag, "_p_lo"}, 99'(lo), 99'(v.lo));
        chk({tag, "_p_mid"}, 99'(mid), 99'(v.mid));
        chk({tag, "_p_hi"}, 99'(hi), 99'(v.hi));
        ovl = 99'(lo) ^ (99'(mid) << 25) ^ (99'(hi) << 50);
        chk({tag, "_overlap"}, ovl, clmul(v.a, v.b));
        if (hold > 0) begin
            bad = 0;
            for (int i = 0; i < hold; i++) begin
                if (junk) in_valid = 1'($urandom_range(1));
                @(posedge clk);
                #1;
                if (!out_valid || in_ready || p_lo !== lo ||
                    p_mid !== mid || p_hi !== hi) bad = 1;
            end
            in_valid = 1'b0;
            chk({tag, "_hold_stable"}, 99'(bad), 99'(0));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_release"}, {97'b0, in_ready, out_valid}, 99'(2));
    endtask

    vec_t tbl[10];
    vec_t v;

    initial begin
        tbl[0] = '{50'd1, 50'd1, 49'd1, 49'd0, 49'd0};
        tbl[1] = '{50'd1 << 25, 50'd1 << 25, 49'd0, 49'd0, 49'd1};
        tbl[2] = '{50'd1, 50'd1 << 25, 49'd0, 49'd1, 49'd0};
        tbl[3] = '{{50{1'b1}}, {50{1'b1}},
                   49'h1555555555555, 49'd0, 49'h1555555555555};
        for (int i = 4; i < 10; i++) tbl[i] = model(rnd50(), rnd50());

        #12;
        chk("reset_in_ready", 99'(in_ready), 99'(1));
        chk("reset_out_valid", 99'(out_valid), 99'(0));
        chk("reset_p", {p_lo, p_mid, 1'b0}, 99'(0));
        chk("reset_p_hi", 99'(p_hi), 99'(0));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++)
            run_op(tbl[i], 0, 0, $sformatf("tbl%0d", i));

        v = model(rnd50(), rnd50());
        run_op(v, 10, 1, "bp");
        for (int i = 0; i < 8; i++)
            run_op(model(rnd50(), rnd50()), $urandom_range(3), 1,
                   $sformatf("rnd%0d", i));

        @(negedge clk);
        a = rnd50();
        b = rnd50();
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", 99'(in_ready), 99'(1));
        chk("midrst_out_valid", 99'(out_valid), 99'(0));
        chk("midrst_p", {p_lo, p_mid, 1'b0}, 99'(0));
        chk("midrst_p_hi", 99'(p_hi), 99'(0));
        @(negedge clk);
        rst_n = 1'b1;
        run_op('{50'd3, 50'd3, 49'd5, 49'd0, 49'd0}, 0, 0, "after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
